// File: rtl/fp_result_queue.sv
// rtl/fp_result_queue.sv - result FIFO between the 1-cycle FP add/sub unit and the commit write port
// Issues start credits so the adder never overruns the FIFO; flush discards queued and in-flight results.
module fp_result_queue #(
   parameter int RV       = 64,
   parameter int LNCOMMIT = 6,
   parameter int NHART    = 1,
   parameter int LNHART   = 1,
   parameter int DEPTH    = 4,
   parameter int LDEPTH   = 2
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic                                issue_start,
   output logic                                can_issue,
   input  logic                                in_valid,
   input  logic                                in_exception,
   input  logic [RV-1:0]                       in_res,
   input  logic [LNCOMMIT-1:0]                 in_rd,
   input  logic [(NHART==1?0:LNHART-1):0]      in_hart,
   input  logic                                flush,
   output logic                                out_valid,
   input  logic                                out_ready,
   output logic [RV-1:0]                       out_res,
   output logic                                out_exception,
   output logic [LNCOMMIT-1:0]                 out_rd,
   output logic [(NHART==1?0:LNHART-1):0]      out_hart,
   output logic                                overflow
);

   logic [RV-1:0]                  r_res  [DEPTH];
   logic                           r_exc  [DEPTH];
   logic [LNCOMMIT-1:0]            r_rd   [DEPTH];
   logic [(NHART==1?0:LNHART-1):0] r_hart [DEPTH];

   logic [LDEPTH-1:0] r_rd_ptr;
   logic [LDEPTH-1:0] r_wr_ptr;
   logic [LDEPTH:0]   r_count;
   logic [LDEPTH:0]   r_inflight;
   logic [LDEPTH:0]   r_drop;
   logic              r_overflow;

   logic [LDEPTH+1:0] w_credit_used;
   logic [LDEPTH:0]   w_inflight_nxt;
   logic              w_full;
   logic              w_pop;
   logic              w_push_req;
   logic              w_push;
   logic              w_discard;
   logic              w_overflow_set;

   // Extra bit keeps the sum from wrapping when inflight is pushed past DEPTH by a bad issuer.
   assign w_credit_used  = {1'b0, r_count} + {1'b0, r_inflight};
   assign can_issue      = (w_credit_used < (LDEPTH+2)'(DEPTH));
   assign w_inflight_nxt = r_inflight + (LDEPTH+1)'(issue_start) - (LDEPTH+1)'(in_valid);

   assign out_valid  = (r_count != '0);
   assign w_full     = (r_count == (LDEPTH+1)'(DEPTH));
   assign w_pop      = out_valid && out_ready && !flush;
   assign w_discard  = in_valid && !flush && (r_drop != '0);
   assign w_push_req = in_valid && !flush && (r_drop == '0);
   assign w_push     = w_push_req && (!w_full || w_pop);

   assign w_overflow_set = (w_push_req && w_full && !w_pop) || (issue_start && !can_issue);

   assign out_res       = r_res[r_rd_ptr];
   assign out_exception = r_exc[r_rd_ptr];
   assign out_rd        = r_rd[r_rd_ptr];
   assign out_hart      = r_hart[r_rd_ptr];
   assign overflow      = r_overflow;

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_res[i]  <= '0;
            r_exc[i]  <= 1'b0;
            r_rd[i]   <= '0;
            r_hart[i] <= '0;
         end
      end else if (w_push) begin
         r_res[r_wr_ptr]  <= in_res;
         r_exc[r_wr_ptr]  <= in_exception;
         r_rd[r_wr_ptr]   <= in_rd;
         r_hart[r_wr_ptr] <= in_hart;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_rd_ptr   <= '0;
         r_wr_ptr   <= '0;
         r_count    <= '0;
         r_inflight <= '0;
         r_drop     <= '0;
         r_overflow <= 1'b0;
      end else begin
         r_inflight <= w_inflight_nxt;
         if (w_overflow_set) begin
            r_overflow <= 1'b1;
         end
         if (flush) begin
            // Everything still owed by the adder, including this cycle's issue, is dropped on arrival.
            r_count  <= '0;
            r_rd_ptr <= r_wr_ptr;
            r_drop   <= w_inflight_nxt;
         end else begin
            if (w_discard) begin
               r_drop <= r_drop - 1'b1;
            end
            if (w_push) begin
               r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
               r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
               r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
               r_count <= r_count - 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_fp_result_queue.sv
// tb/tb_fp_result_queue.sv - self-checking bench for fp_result_queue
// Reference model: queue of ops owed by the adder (each marked doomed or not) and a queue of FIFO contents.
module tb_fp_result_queue;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        issue_start = 1'b0;
   logic        can_issue;
   logic        in_valid = 1'b0;
   logic        in_exception = 1'b0;
   logic [63:0] in_res = '0;
   logic [5:0]  in_rd = '0;
   logic [0:0]  in_hart = '0;
   logic        flush = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [63:0] out_res;
   logic        out_exception;
   logic [5:0]  out_rd;
   logic [0:0]  out_hart;
   logic        overflow;

   fp_result_queue dut (
      .clk(clk), .reset(reset), .issue_start(issue_start), .can_issue(can_issue),
      .in_valid(in_valid), .in_exception(in_exception), .in_res(in_res), .in_rd(in_rd),
      .in_hart(in_hart), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
      .out_res(out_res), .out_exception(out_exception), .out_rd(out_rd), .out_hart(out_hart),
      .overflow(overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] res;
      logic        exc;
      logic [5:0]  rd;
      logic        hart;
      bit          doomed;
   } op_t;

   op_t pend[$];
   op_t fifo[$];
   bit  m_ov;
   int  total = 0;
   int  bad = 0;
   int  npop = 0;

   logic [63:0] nxt_res;
   logic        nxt_exc;
   logic [5:0]  nxt_rd;
   logic        nxt_hart;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic bit m_can();
      return (fifo.size() + pend.size()) < DEPTH;
   endfunction

   task automatic randomize_next();
      nxt_res  = {$urandom, $urandom};
      nxt_exc  = 1'($urandom_range(0, 1));
      nxt_rd   = 6'($urandom_range(0, 63));
      nxt_hart = 1'($urandom_range(0, 1));
   endtask

   task automatic check_model();
      chk("out_valid", out_valid, fifo.size() != 0);
      if (fifo.size() != 0) begin
         chk("out_res", out_res, fifo[0].res);
         chk("out_exception", out_exception, fifo[0].exc);
         chk("out_rd", out_rd, fifo[0].rd);
         chk("out_hart", out_hart, fifo[0].hart);
      end
      chk("can_issue", can_issue, m_can());
      chk("overflow", overflow, m_ov);
   endtask

   // One clock: drive at negedge, advance model, check after the edge at the next negedge.
   task automatic cyc(input bit iss, input bit rdy, input bit fl, input bit spur = 1'b0);
      op_t op;
      op_t arr;
      bit  have_arr;
      bit  pop;
      bit  was_full;
      op = '{res: nxt_res, exc: nxt_exc, rd: nxt_rd, hart: nxt_hart, doomed: fl};
      have_arr = 1'b0;
      arr = op;
      arr.doomed = 1'b0;
      if (iss && !m_can()) m_ov = 1'b1;
      if (pend.size() != 0) begin
         arr = pend.pop_front();
         have_arr = 1'b1;
      end else if (spur) begin
         have_arr = 1'b1;
      end
      issue_start  = iss;
      out_ready    = rdy;
      flush        = fl;
      in_valid     = have_arr;
      in_res       = have_arr ? arr.res : {$urandom, $urandom};
      in_exception = have_arr ? arr.exc : 1'($urandom_range(0, 1));
      in_rd        = have_arr ? arr.rd : 6'($urandom_range(0, 63));
      in_hart      = have_arr ? arr.hart : 1'($urandom_range(0, 1));
      was_full = (fifo.size() == DEPTH);
      pop = (fifo.size() != 0) && rdy && !fl;
      if (pop) begin
         void'(fifo.pop_front());
         npop++;
      end
      if (have_arr && !fl && !arr.doomed) begin
         if (was_full && !pop) m_ov = 1'b1;
         else fifo.push_back(arr);
      end
      if (fl) begin
         fifo.delete();
         foreach (pend[i]) pend[i].doomed = 1'b1;
      end
      if (iss) pend.push_back(op);
      @(negedge clk);
      check_model();
      randomize_next();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      issue_start = 1'b0;
      in_valid = 1'b0;
      flush = 1'b0;
      out_ready = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_can_issue", can_issue, 1'b1);
      chk("rst_overflow", overflow, 1'b0);
      chk("rst_out_res", out_res, 64'h0);
      chk("rst_out_exception", out_exception, 1'b0);
      chk("rst_out_rd", out_rd, 6'd0);
      chk("rst_out_hart", out_hart, 1'b0);
      reset = 1'b0;
      pend.delete();
      fifo.delete();
      m_ov = 1'b0;
   endtask

   initial begin
      int issued;
      int start_pops;
      m_ov = 1'b0;
      randomize_next();
      do_reset();

      // Single op
      nxt_res = 64'h3ff0_0000_0000_0000;
      nxt_rd  = 6'd5;
      cyc(1, 0, 0);
      cyc(0, 0, 0);
      chk("single_valid", out_valid, 1'b1);
      chk("single_res", out_res, 64'h3ff0_0000_0000_0000);
      chk("single_rd", out_rd, 6'd5);
      cyc(0, 1, 0);
      chk("single_empty", out_valid, 1'b0);

      // Backpressure fill and in-order drain
      for (int k = 1; k <= 4; k++) begin
         nxt_rd = 6'(k);
         cyc(1, 0, 0);
      end
      chk("fill_can_issue", can_issue, 1'b0);
      cyc(0, 0, 0);
      chk("fill_overflow", overflow, 1'b0);
      for (int k = 1; k <= 4; k++) begin
         chk("drain_rd", out_rd, 6'(k));
         cyc(0, 1, 0);
         if (k == 1) chk("credit_return", can_issue, 1'b1);
      end

      // Wrap-around: 10 ops, out_ready toggling
      issued = 0;
      start_pops = npop;
      for (int c = 0; c < 200 && (npop - start_pops) < 10; c++) begin
         bit iss;
         iss = (issued < 10) && m_can();
         if (iss) begin
            nxt_rd = 6'(20 + issued);
            issued++;
         end
         cyc(iss, c[0], 0);
      end
      chk("wrap_delivered", 64'(npop - start_pops), 64'd10);
      chk("wrap_overflow", overflow, 1'b0);

      // Flush with in-flight work
      do_reset();
      nxt_rd = 6'd1; cyc(1, 0, 0);
      nxt_rd = 6'd2; cyc(1, 0, 0);
      cyc(0, 0, 0);
      nxt_rd = 6'd7; cyc(1, 0, 1);
      chk("flush_empty", out_valid, 1'b0);
      cyc(0, 0, 0);
      chk("flush_discard", out_valid, 1'b0);
      nxt_rd = 6'd9; cyc(1, 0, 0);
      cyc(0, 0, 0);
      chk("flush_new_valid", out_valid, 1'b1);
      chk("flush_new_rd", out_rd, 6'd9);

      // Push and pop together at full (arrival driven directly by the bench)
      do_reset();
      for (int k = 1; k <= 4; k++) begin
         nxt_rd = 6'(k);
         cyc(1, 0, 0);
      end
      cyc(0, 0, 0);
      nxt_rd = 6'd10;
      cyc(0, 1, 0, 1);
      chk("full_pp_valid", out_valid, 1'b1);
      chk("full_pp_head", out_rd, 6'd2);
      chk("full_pp_overflow", overflow, 1'b0);

      // Protocol violation: issue without credit
      do_reset();
      for (int k = 1; k <= 4; k++) cyc(1, 0, 0);
      cyc(0, 0, 0);
      cyc(1, 0, 0);
      chk("viol_overflow", overflow, 1'b1);
      cyc(0, 0, 0);
      cyc(0, 1, 0);
      cyc(0, 1, 0);
      chk("viol_sticky", overflow, 1'b1);
      do_reset();

      // Random traffic with occasional flush and one mid-run reset
      for (int c = 0; c < 600; c++) begin
         if (c == 300) do_reset();
         cyc(m_can() && ($urandom_range(0, 3) != 0),
             $urandom_range(0, 2) != 0,
             $urandom_range(0, 19) == 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
